alu_issue_arb: RTL and testbench
================================

ALU_ISSUE_ARB -- requirements
Module: alu_issue_arb

Interface
REQ-001 Parameter: ROB_SIZE_BIT, 4, width of ROB index.
REQ-002 Parameter: RS_TYPE_BIT, 6, width of operation-type code.
REQ-003 clk_in  input  1  system clock; one clock domain, all state on its rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-high.
REQ-005 rdy_in  input  1  global ready; when low the block SHALL hold all state.
REQ-006 flush  input  1  mispredict clear; squashes buffered and in-flight work.
REQ-007 req_valid[1:0]  input  2  per-requester valid (0 = arithmetic RS, 1 = branch RS).
REQ-008 req_r1_k, req_r2_k  input  32 each  operands of requester k.
REQ-009 req_rob_k  input  ROB_SIZE_BIT  ROB index of requester k.
REQ-010 req_op_k  input  RS_TYPE_BIT  op type of requester k (01yxxx arith, 110xxx branch).
REQ-011 req_ready[1:0]  output  2  per-requester accept signal.
REQ-012 alu_valid  output  1  registered issue valid to ALU.
REQ-013 alu_r1, alu_r2  output  32 each  registered operands to ALU.
REQ-014 alu_rob  output  ROB_SIZE_BIT  registered ROB index to ALU.
REQ-015 alu_op  output  RS_TYPE_BIT  registered op type to ALU.
REQ-016 alu_ready, alu_result, alu_rob_in  input  1/32/ROB_SIZE_BIT  ALU completion, 1-cycle latency after issue.
REQ-017 res_valid[1:0]  output  2  completion routed to requester that issued it.
REQ-018 res_data, res_rob  output  32/ROB_SIZE_BIT  pass-through of alu_result, alu_rob_in.

Function
REQ-019 Each requester SHALL own a one-entry holding buffer (valid bit + r1, r2, rob, op).
REQ-020 req_ready[k] SHALL be combinational: rdy_in & !flush & (!buf_valid[k] | grant[k]).
REQ-021 Transfer on requester k: req_valid[k] & req_ready[k] at a rising edge; payload written into buffer k.
REQ-022 Grant each cycle: one buffer only valid -> that one; both valid -> buffer rr_ptr; neither -> no grant.
REQ-023 rr_ptr SHALL toggle to the non-granted index only when both buffers were valid and a grant occurred; otherwise it holds.
REQ-024 On grant to k: alu_valid<=1, alu_r1/r2/rob/op <= buffer k, issue_src<=k; buffer k cleared unless refilled same edge (REQ-021 wins).
REQ-025 No grant: alu_valid<=0; alu payload registers hold last value.
REQ-026 Issue rate: at most one per cycle; back-to-back issue from alternating requesters sustained when both keep buffers full.
REQ-027 inflight_src SHALL capture issue_src on each edge where alu_valid is 1; inflight_live captures alu_valid & !flush.
REQ-028 res_valid[k] = alu_ready & inflight_live & (inflight_src==k) & !flush; res_data/res_rob driven from ALU unconditionally.
REQ-029 flush (with rdy_in high): both buffers cleared, alu_valid<=0, inflight_live<=0, incoming requests ignored, rr_ptr<=0.
REQ-030 flush SHALL take priority over new transfers and grants on the same edge.
REQ-031 rdy_in low: no transfers, no grants, no pointer change, alu_valid and all buffers hold; flush ignored.
REQ-032 Arithmetic op codes pass unmodified; the block SHALL NOT decode op types beyond routing.

Reset
REQ-033 On rst_in (asynchronous): buffers invalid, alu_valid=0, alu_r1/r2/rob/op=0, rr_ptr=0, issue_src=0, inflight_src=0, inflight_live=0.
REQ-034 During and immediately after reset req_ready SHALL equal rdy_in & !flush (buffers empty); res_valid=0.
REQ-035 Reset asserted mid-issue SHALL drop all buffered and in-flight work without producing res_valid.

Verification
REQ-036 Req0 only, r1=5, r2=3, op=010000 (ADD), rob=2 -> alu_valid next cycle with 5/3/rob 2; ALU result 8 -> res_valid=01, res_rob=2.
REQ-037 Both requesters valid every cycle from reset -> grants 0,1,0,1...; res_valid alternates 01,10; no request lost.
REQ-038 Req1 BEQ r1=r2=7, rob=9 issued, flush in result cycle -> res_valid=00; buffers empty; req_ready=11 after flush drops.
REQ-039 rdy_in low for 3 cycles with both buffers full -> req_ready=00, alu outputs frozen; resume -> issue order unchanged.
REQ-040 Async reset pulse between clock edges while alu_valid=1 -> alu_valid=0 immediately, no res_valid on following cycles.
REQ-041 Buffer 0 full, req0 re-presents same cycle it is granted -> accepted (req_ready[0]=1), next issue carries new payload.

Source files
------------

// File: rtl/alu_issue_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_arb
// Brief    : Two-requester issue arbiter in front of a single ALU. Each
//            requester (0 = arithmetic RS, 1 = branch RS) owns a one-entry
//            holding buffer. Round-robin grant issues at most one op per
//            cycle. ALU completions are routed back to the requester that
//            issued them. Mispredict flush squashes all buffered and
//            in-flight work.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_arb #(
    parameter int ROB_SIZE_BIT = 4,
    parameter int RS_TYPE_BIT  = 6
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush,

    input  logic [1:0]              req_valid,
    input  logic [31:0]             req_r1_0,
    input  logic [31:0]             req_r2_0,
    input  logic [ROB_SIZE_BIT-1:0] req_rob_0,
    input  logic [RS_TYPE_BIT-1:0]  req_op_0,
    input  logic [31:0]             req_r1_1,
    input  logic [31:0]             req_r2_1,
    input  logic [ROB_SIZE_BIT-1:0] req_rob_1,
    input  logic [RS_TYPE_BIT-1:0]  req_op_1,
    output logic [1:0]              req_ready,

    output logic                    alu_valid,
    output logic [31:0]             alu_r1,
    output logic [31:0]             alu_r2,
    output logic [ROB_SIZE_BIT-1:0] alu_rob,
    output logic [RS_TYPE_BIT-1:0]  alu_op,

    input  logic                    alu_ready,
    input  logic [31:0]             alu_result,
    input  logic [ROB_SIZE_BIT-1:0] alu_rob_in,

    output logic [1:0]              res_valid,
    output logic [31:0]             res_data,
    output logic [ROB_SIZE_BIT-1:0] res_rob
);

    // Holding buffers, one entry per requester
    logic [1:0]              r_buf_valid;
    logic [31:0]             r_buf_r1  [2];
    logic [31:0]             r_buf_r2  [2];
    logic [ROB_SIZE_BIT-1:0] r_buf_rob [2];
    logic [RS_TYPE_BIT-1:0]  r_buf_op  [2];

    // Arbitration and completion-tracking state
    logic r_rr_ptr;
    logic r_issue_src;
    logic r_inflight_src;
    logic r_inflight_live;

    // Incoming payloads gathered into arrays so the buffer update can loop
    logic [31:0]             w_in_r1  [2];
    logic [31:0]             w_in_r2  [2];
    logic [ROB_SIZE_BIT-1:0] w_in_rob [2];
    logic [RS_TYPE_BIT-1:0]  w_in_op  [2];

    logic       w_both;
    logic       w_any;
    logic       w_gidx;
    logic [1:0] w_grant;
    logic       w_adv;
    logic [1:0] w_xfer;

    assign w_in_r1[0]  = req_r1_0;
    assign w_in_r1[1]  = req_r1_1;
    assign w_in_r2[0]  = req_r2_0;
    assign w_in_r2[1]  = req_r2_1;
    assign w_in_rob[0] = req_rob_0;
    assign w_in_rob[1] = req_rob_1;
    assign w_in_op[0]  = req_op_0;
    assign w_in_op[1]  = req_op_1;

    // Grant selection: a lone valid buffer wins; with both valid the
    // round-robin pointer decides.
    assign w_both  = &r_buf_valid;
    assign w_any   = |r_buf_valid;
    assign w_gidx  = w_both ? r_rr_ptr : r_buf_valid[1];
    assign w_grant = w_any ? (w_gidx ? 2'b10 : 2'b01) : 2'b00;

    // The block only advances when globally ready and not flushing
    assign w_adv     = rdy_in & ~flush;
    // A buffer being drained this cycle can accept a refill on the same edge
    assign req_ready = {2{w_adv}} & (~r_buf_valid | w_grant);
    assign w_xfer    = req_valid & req_ready;

    // Buffer fill/drain: refill beats drain, flush clears everything
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_buf_valid <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                r_buf_r1[k]  <= '0;
                r_buf_r2[k]  <= '0;
                r_buf_rob[k] <= '0;
                r_buf_op[k]  <= '0;
            end
        end else if (rdy_in) begin
            for (int k = 0; k < 2; k++) begin
                if (flush) begin
                    r_buf_valid[k] <= 1'b0;
                end else if (w_xfer[k]) begin
                    r_buf_valid[k] <= 1'b1;
                    r_buf_r1[k]    <= w_in_r1[k];
                    r_buf_r2[k]    <= w_in_r2[k];
                    r_buf_rob[k]   <= w_in_rob[k];
                    r_buf_op[k]    <= w_in_op[k];
                end else if (w_grant[k]) begin
                    r_buf_valid[k] <= 1'b0;
                end
            end
        end
    end

    // Issue register toward the ALU plus round-robin pointer update
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            alu_valid   <= 1'b0;
            alu_r1      <= '0;
            alu_r2      <= '0;
            alu_rob     <= '0;
            alu_op      <= '0;
            r_issue_src <= 1'b0;
            r_rr_ptr    <= 1'b0;
        end else if (rdy_in) begin
            if (flush) begin
                alu_valid <= 1'b0;
                r_rr_ptr  <= 1'b0;
            end else if (w_any) begin
                alu_valid   <= 1'b1;
                alu_r1      <= r_buf_r1[w_gidx];
                alu_r2      <= r_buf_r2[w_gidx];
                alu_rob     <= r_buf_rob[w_gidx];
                alu_op      <= r_buf_op[w_gidx];
                r_issue_src <= w_gidx;
                // Pointer moves only when there was actual contention
                if (w_both) begin
                    r_rr_ptr <= ~w_gidx;
                end
            end else begin
                alu_valid <= 1'b0;
            end
        end
    end

    // Track which requester owns the op currently inside the ALU
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_inflight_src  <= 1'b0;
            r_inflight_live <= 1'b0;
        end else if (rdy_in) begin
            if (alu_valid) begin
                r_inflight_src <= r_issue_src;
            end
            r_inflight_live <= alu_valid & ~flush;
        end
    end

    // Completion routing; data and ROB tag are plain pass-throughs
    assign res_valid = {2{alu_ready & r_inflight_live & ~flush}}
                     & {r_inflight_src, ~r_inflight_src};
    assign res_data  = alu_result;
    assign res_rob   = alu_rob_in;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_arb
// Brief    : Directed-vector testbench for alu_issue_arb with a one-cycle
//            adder standing in for the ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_arb;

    localparam logic [5:0] OP0 = 6'b010000;  // ADD from arithmetic RS
    localparam logic [5:0] OP1 = 6'b110000;  // BEQ from branch RS

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic [1:0]  req_valid;
    logic [31:0] req_r1_0, req_r2_0, req_r1_1, req_r2_1;
    logic [3:0]  req_rob_0, req_rob_1;
    logic [5:0]  req_op_0, req_op_1;
    logic [1:0]  req_ready;
    logic        alu_valid;
    logic [31:0] alu_r1, alu_r2;
    logic [3:0]  alu_rob;
    logic [5:0]  alu_op;
    logic        alu_ready;
    logic [31:0] alu_result;
    logic [3:0]  alu_rob_in;
    logic [1:0]  res_valid;
    logic [31:0] res_data;
    logic [3:0]  res_rob;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_in = ~clk_in;

    alu_issue_arb #(.ROB_SIZE_BIT(4), .RS_TYPE_BIT(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .req_valid(req_valid),
        .req_r1_0(req_r1_0), .req_r2_0(req_r2_0), .req_rob_0(req_rob_0), .req_op_0(req_op_0),
        .req_r1_1(req_r1_1), .req_r2_1(req_r2_1), .req_rob_1(req_rob_1), .req_op_1(req_op_1),
        .req_ready(req_ready),
        .alu_valid(alu_valid), .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_rob(alu_rob), .alu_op(alu_op),
        .alu_ready(alu_ready), .alu_result(alu_result), .alu_rob_in(alu_rob_in),
        .res_valid(res_valid), .res_data(res_data), .res_rob(res_rob)
    );

    // Stand-in ALU: adds the operands, answers one cycle after issue
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            alu_ready  <= 1'b0;
            alu_result <= '0;
            alu_rob_in <= '0;
        end else begin
            alu_ready  <= alu_valid;
            alu_result <= alu_r1 + alu_r2;
            alu_rob_in <= alu_rob;
        end
    end

    typedef struct {
        logic        rdy, fl;
        logic [1:0]  rv;
        logic [31:0] a0, b0;
        logic [3:0]  rob0;
        logic [31:0] a1, b1;
        logic [3:0]  rob1;
        logic [1:0]  e_rdy, e_res;
        logic [3:0]  e_rrob;
        logic [31:0] e_rdata;
        logic        e_av;
        logic [31:0] e_r1;
        logic [3:0]  e_rob;
        logic [5:0]  e_op;
    } vec_t;

    function automatic vec_t mk(
        input logic rdy, input logic fl, input logic [1:0] rv,
        input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] rob0,
        input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] rob1,
        input logic [1:0] e_rdy, input logic [1:0] e_res,
        input logic [3:0] e_rrob, input logic [31:0] e_rdata,
        input logic e_av, input logic [31:0] e_r1, input logic [3:0] e_rob,
        input logic [5:0] e_op);
        vec_t v;
        v.rdy = rdy; v.fl = fl; v.rv = rv;
        v.a0 = a0; v.b0 = b0; v.rob0 = rob0;
        v.a1 = a1; v.b1 = b1; v.rob1 = rob1;
        v.e_rdy = e_rdy; v.e_res = e_res; v.e_rrob = e_rrob; v.e_rdata = e_rdata;
        v.e_av = e_av; v.e_r1 = e_r1; v.e_rob = e_rob; v.e_op = e_op;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    vec_t vecs[$];

    initial begin
        // --- single ADD from requester 0 ---
        vecs.push_back(mk(1,0,2'b01, 5,3,2,       0,0,0,        2'b11,2'b00,0,0,       0,0,0,0));
        vecs.push_back(mk(1,0,2'b00, 0,0,0,       0,0,0,        2'b11,2'b00,0,0,       1,5,2,OP0));
        vecs.push_back(mk(1,0,2'b00, 0,0,0,       0,0,0,        2'b11,2'b00,0,0,       0,5,2,OP0));
        vecs.push_back(mk(1,0,2'b00, 0,0,0,       0,0,0,        2'b11,2'b01,2,8,       0,5,2,OP0));
        // --- both requesters streaming: alternating grants ---
        vecs.push_back(mk(1,0,2'b11, 'h10,1,1,   'h20,1,9,     2'b11,2'b00,0,0,       0,5,2,OP0));
        vecs.push_back(mk(1,0,2'b11, 'h11,1,3,   'h21,1,10,    2'b01,2'b00,0,0,       1,'h10,1,OP0));
        vecs.push_back(mk(1,0,2'b11, 'h12,1,4,   'h21,1,10,    2'b10,2'b00,0,0,       1,'h20,9,OP1));
        vecs.push_back(mk(1,0,2'b11, 'h12,1,4,   'h22,1,11,    2'b01,2'b01,1,'h11,    1,'h11,3,OP0));
        vecs.push_back(mk(1,0,2'b10, 0,0,0,       'h22,1,11,    2'b10,2'b10,9,'h21,    1,'h21,10,OP1));
        vecs.push_back(mk(1,0,2'b00, 0,0,0,       0,0,0,        2'b01,2'b01,3,'h12,    1,'h12,4,OP0));
        vecs.push_back(mk(1,0,2'b00, 0,0,0,       0,0,0,        2'b11,2'b10,10,'h22,   1,'h22,11,OP1));
        vecs.push_back(mk(1,0,2'b00, 0,0,0,       0,0,0,        2'b11,2'b01,4,'h13,    0,'h22,11,OP1));
        vecs.push_back(mk(1,0,2'b00, 0,0,0,       0,0,0,        2'b11,2'b10,11,'h23,   0,'h22,11,OP1));
        // --- stall with both buffers full, then resume ---
        vecs.push_back(mk(1,0,2'b11, 'h30,1,2,   'h40,1,12,    2'b11,2'b00,0,0,       0,'h22,11,OP1));
        vecs.push_back(mk(1,0,2'b11, 'h31,1,3,   'h41,1,13,    2'b10,2'b00,0,0,       1,'h40,12,OP1));
        vecs.push_back(mk(0,0,2'b11, 'h31,1,3,   'h42,1,14,    2'b00,2'b00,0,0,       1,'h40,12,OP1));
        vecs.push_back(mk(0,0,2'b11, 'h31,1,3,   'h42,1,14,    2'b00,2'b00,0,0,       1,'h40,12,OP1));
        vecs.push_back(mk(0,0,2'b11, 'h31,1,3,   'h42,1,14,    2'b00,2'b00,0,0,       1,'h40,12,OP1));
        vecs.push_back(mk(1,0,2'b11, 'h31,1,3,   'h42,1,14,    2'b01,2'b00,0,0,       1,'h30,2,OP0));
        vecs.push_back(mk(1,0,2'b10, 0,0,0,       'h42,1,14,    2'b10,2'b10,12,'h41,   1,'h41,13,OP1));
        vecs.push_back(mk(1,0,2'b00, 0,0,0,       0,0,0,        2'b01,2'b01,2,'h31,    1,'h31,3,OP0));
        vecs.push_back(mk(1,0,2'b00, 0,0,0,       0,0,0,        2'b11,2'b10,13,'h42,   1,'h42,14,OP1));
        vecs.push_back(mk(1,0,2'b00, 0,0,0,       0,0,0,        2'b11,2'b01,3,'h32,    0,'h42,14,OP1));
        vecs.push_back(mk(1,0,2'b00, 0,0,0,       0,0,0,        2'b11,2'b10,14,'h43,   0,'h42,14,OP1));
        // --- BEQ from requester 1, flush in its result cycle ---
        vecs.push_back(mk(1,0,2'b10, 0,0,0,       7,7,9,        2'b11,2'b00,0,0,       0,'h42,14,OP1));
        vecs.push_back(mk(1,0,2'b00, 0,0,0,       0,0,0,        2'b11,2'b00,0,0,       1,7,9,OP1));
        vecs.push_back(mk(1,0,2'b00, 0,0,0,       0,0,0,        2'b11,2'b00,0,0,       0,7,9,OP1));
        vecs.push_back(mk(1,1,2'b11, 'h50,1,5,   'h60,1,6,     2'b00,2'b00,0,0,       0,7,9,OP1));
        vecs.push_back(mk(1,0,2'b00, 0,0,0,       0,0,0,        2'b11,2'b00,0,0,       0,7,9,OP1));
        // --- flush with both buffers full drops them ---
        vecs.push_back(mk(1,0,2'b11, 'h50,1,5,   'h60,1,6,     2'b11,2'b00,0,0,       0,7,9,OP1));
        vecs.push_back(mk(1,1,2'b00, 0,0,0,       0,0,0,        2'b00,2'b00,0,0,       0,7,9,OP1));
        vecs.push_back(mk(1,0,2'b00, 0,0,0,       0,0,0,        2'b11,2'b00,0,0,       0,7,9,OP1));

        // Reset state
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; req_valid = 2'b00;
        req_r1_0 = '0; req_r2_0 = '0; req_rob_0 = '0; req_op_0 = OP0;
        req_r1_1 = '0; req_r2_1 = '0; req_rob_1 = '0; req_op_1 = OP1;
        repeat (2) @(posedge clk_in);
        #1;
        chk("reset alu_valid", {31'd0, alu_valid}, 0);
        chk("reset alu_r1",    alu_r1, 0);
        chk("reset alu_rob",   {28'd0, alu_rob}, 0);
        chk("reset alu_op",    {26'd0, alu_op}, 0);
        chk("reset req_ready", {30'd0, req_ready}, 2'b11);
        chk("reset res_valid", {30'd0, res_valid}, 0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Table-driven vectors
        foreach (vecs[i]) begin
            @(negedge clk_in);
            rdy_in = vecs[i].rdy; flush = vecs[i].fl; req_valid = vecs[i].rv;
            req_r1_0 = vecs[i].a0; req_r2_0 = vecs[i].b0; req_rob_0 = vecs[i].rob0;
            req_r1_1 = vecs[i].a1; req_r2_1 = vecs[i].b1; req_rob_1 = vecs[i].rob1;
            #1;
            chk($sformatf("v%0d req_ready", i), {30'd0, req_ready}, {30'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d res_valid", i), {30'd0, res_valid}, {30'd0, vecs[i].e_res});
            if (vecs[i].e_res != 2'b00) begin
                chk($sformatf("v%0d res_rob", i),  {28'd0, res_rob}, {28'd0, vecs[i].e_rrob});
                chk($sformatf("v%0d res_data", i), res_data, vecs[i].e_rdata);
            end
            @(posedge clk_in);
            #1;
            chk($sformatf("v%0d alu_valid", i), {31'd0, alu_valid}, {31'd0, vecs[i].e_av});
            chk($sformatf("v%0d alu_r1", i),    alu_r1, vecs[i].e_r1);
            chk($sformatf("v%0d alu_rob", i),   {28'd0, alu_rob}, {28'd0, vecs[i].e_rob});
            chk($sformatf("v%0d alu_op", i),    {26'd0, alu_op}, {26'd0, vecs[i].e_op});
        end

        // Asynchronous reset pulse between edges while an op is issued
        @(negedge clk_in);
        rdy_in = 1'b1; flush = 1'b0; req_valid = 2'b01;
        req_r1_0 = 'h70; req_r2_0 = 1; req_rob_0 = 7;
        @(negedge clk_in);
        req_valid = 2'b00;
        @(posedge clk_in);
        #1;
        chk("pre-reset alu_valid", {31'd0, alu_valid}, 1);
        chk("pre-reset alu_r1",    alu_r1, 'h70);
        #2;
        rst_in = 1'b1;
        #1;
        chk("async reset alu_valid", {31'd0, alu_valid}, 0);
        chk("async reset alu_r1",    alu_r1, 0);
        chk("async reset req_ready", {30'd0, req_ready}, 2'b11);
        #1;
        rst_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            #1;
            chk($sformatf("post-reset c%0d res_valid", c), {30'd0, res_valid}, 0);
            @(posedge clk_in);
            #1;
            chk($sformatf("post-reset c%0d alu_valid", c), {31'd0, alu_valid}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
